// File: rtl/apb_master_sched.sv
// apb_master_sched
//   Round-robin scheduler that shares one APB master port between NREQ
//   requesters. Each granted transfer is sequenced through the APB setup and
//   access phases, with Pselx decoded from the latched address. Pready wait
//   states and Pslverr are handled. A wait-state timeout aborts the transfer
//   with an error. Every output is registered.
//
// Ports
//   clk, rst              clock (posedge) and synchronous active-high reset
//   req/req_write         per-requester request level and direction (1=write)
//   req_addr/req_wdata    per-requester address / write data, slot i at [32*i+:32]
//   gnt                   one-hot owner of the bus
//   done                  one-hot single-cycle completion pulse
//   rsp_rdata/rsp_err     response data / error, valid with done
//   Paddr/Pwrite/Pwdata   APB address, direction, write data
//   Pselx/Penable         APB one-hot slave select and enable
//   Pready/Prdata/Pslverr APB slave handshake, read data, error
module apb_master_sched #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [31:0]          Paddr,
  output logic                 Pwrite,
  output logic [2:0]           Pselx,
  output logic                 Penable,
  output logic [31:0]          Pwdata,
  input  logic                 Pready,
  input  logic [31:0]          Prdata,
  input  logic                 Pslverr
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  // Each slave owns a 64 MB window starting at 0x8000_0000; the top six
  // address bits identify the window.
  function automatic logic [2:0] decode_sel(input logic [31:0] addr);
    logic [2:0] sel;
    case (addr[31:26])
      6'b100000: sel = 3'b001;
      6'b100001: sel = 3'b010;
      6'b100010: sel = 3'b100;
      default:   sel = 3'b000;
    endcase
    return sel;
  endfunction

  state_t             state_r, state_s;
  logic [PW-1:0]      ptr_r, ptr_s, gidx_r, gidx_s, ptr_next_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [31:0]        addr_r, addr_s, wdata_r, wdata_s, rdata_r, rdata_s;
  logic               write_r, write_s, err_r, err_s, penable_r, penable_s;
  logic [NREQ-1:0]    gnt_r, gnt_s, done_r, done_s;
  logic [2:0]         psel_r, psel_s;

  logic               hi_found_s, lo_found_s, arb_any_s, arb_write_s;
  logic [PW-1:0]      hi_idx_s, lo_idx_s, arb_idx_s;
  logic [NREQ-1:0]    arb_oh_s;
  logic [31:0]        arb_addr_s, arb_wdata_s;
  logic [2:0]         arb_sel_s;

  // Round-robin pick: first request at or above ptr, else first below it.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (i >= int'(ptr_r)) && !hi_found_s) begin
        hi_found_s = 1'b1;
        hi_idx_s   = PW'(i);
      end else if (req[i] && !lo_found_s) begin
        lo_found_s = 1'b1;
        lo_idx_s   = PW'(i);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    arb_any_s = hi_found_s | lo_found_s;
    arb_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
  end

  // Mux the winner's request fields and build its one-hot grant.
  always_comb begin
    arb_oh_s    = '0;
    arb_addr_s  = 32'h0000_0000;
    arb_wdata_s = 32'h0000_0000;
    arb_write_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_any_s && (arb_idx_s == PW'(i))) begin
        arb_oh_s[i] = 1'b1;
        arb_addr_s  = req_addr[32*i +: 32];
        arb_wdata_s = req_wdata[32*i +: 32];
        arb_write_s = req_write[i];
      end else begin
        arb_oh_s[i] = 1'b0;
      end
    end
    arb_sel_s = decode_sel(arb_addr_s);
  end

  assign ptr_next_s = (gidx_r == PW'(NREQ - 1)) ? '0 : gidx_r + PW'(1);

  // Next-state and next-output logic; done defaults low so it only pulses.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    gidx_s    = gidx_r;
    cnt_s     = cnt_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    write_s   = write_r;
    gnt_s     = gnt_r;
    done_s    = '0;
    rdata_s   = rdata_r;
    err_s     = err_r;
    psel_s    = psel_r;
    penable_s = penable_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_any_s) begin
          gidx_s  = arb_idx_s;
          gnt_s   = arb_oh_s;
          addr_s  = arb_addr_s;
          wdata_s = arb_wdata_s;
          write_s = arb_write_s;
          if (arb_sel_s != 3'b000) begin
            psel_s  = arb_sel_s;
            state_s = ST_SETUP;
          end else begin
            // Unmapped: answer immediately, the APB port stays quiet.
            done_s  = arb_oh_s;
            err_s   = 1'b1;
            rdata_s = 32'h0000_0000;
            state_s = ST_ERR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_s = 1'b1;
        state_s   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (Pready) begin
          rdata_s   = Prdata;
          err_s     = Pslverr;
          psel_s    = 3'b000;
          penable_s = 1'b0;
          done_s    = gnt_r;
          state_s   = ST_RESP;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle without Pready: abort.
          cnt_s     = cnt_r + CW'(1);
          rdata_s   = 32'h0000_0000;
          err_s     = 1'b1;
          psel_s    = 3'b000;
          penable_s = 1'b0;
          done_s    = gnt_r;
          state_s   = ST_RESP;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_RESP, ST_ERR: begin
        gnt_s   = '0;
        cnt_s   = '0;
        ptr_s   = ptr_next_s;
        state_s = ST_IDLE;
      end
      default: begin
        gnt_s     = '0;
        cnt_s     = '0;
        psel_s    = 3'b000;
        penable_s = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      gidx_r    <= '0;
      cnt_r     <= '0;
      addr_r    <= 32'h0000_0000;
      wdata_r   <= 32'h0000_0000;
      write_r   <= 1'b0;
      gnt_r     <= '0;
      done_r    <= '0;
      rdata_r   <= 32'h0000_0000;
      err_r     <= 1'b0;
      psel_r    <= 3'b000;
      penable_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      gidx_r    <= gidx_s;
      cnt_r     <= cnt_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      write_r   <= write_s;
      gnt_r     <= gnt_s;
      done_r    <= done_s;
      rdata_r   <= rdata_s;
      err_r     <= err_s;
      psel_r    <= psel_s;
      penable_r <= penable_s;
    end
  end

  assign gnt       = gnt_r;
  assign done      = done_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
  assign Paddr     = addr_r;
  assign Pwrite    = write_r;
  assign Pwdata    = wdata_r;
  assign Pselx     = psel_r;
  assign Penable   = penable_r;

endmodule

// File: tb/tb_apb_master_sched.sv
// tb_apb_master_sched
//   Directed and randomized transfers against a transaction-level model:
//   round-robin pointer, address-window decode, and expected cycle timing.
module tb_apb_master_sched;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 16;
  localparam int AW      = NREQ * 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req, req_write, gnt, done;
  logic [AW-1:0]   req_addr, req_wdata;
  logic [31:0]     rsp_rdata, Paddr, Pwdata, Prdata;
  logic            rsp_err, Pwrite, Penable, Pready, Pslverr;
  logic [2:0]      Pselx;

  int n_assert = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  logic [AW-1:0]   ad, wd;
  logic [NREQ-1:0] rq, wr;
  int              waits;

  apb_master_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Paddr(Paddr), .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable), .Pwdata(Pwdata),
    .Pready(Pready), .Prdata(Prdata), .Pslverr(Pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot(input logic [AW-1:0] v, input int i);
    return 32'(v >> (32 * i));
  endfunction

  function automatic logic [AW-1:0] put(input logic [AW-1:0] v, input int i, input logic [31:0] x);
    logic [AW-1:0] m;
    m = AW'(32'hFFFF_FFFF) << (32 * i);
    return (v & ~m) | (AW'(x) << (32 * i));
  endfunction

  // Reference decode by plain address ranges.
  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8400_0000) return 3'b001;
    else if (a >= 32'h8400_0000 && a < 32'h8800_0000) return 3'b010;
    else if (a >= 32'h8800_0000 && a < 32'h8C00_0000) return 3'b100;
    else return 3'b000;
  endfunction

  // Reference arbiter: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (1'(r >> i)) return i;
    end
    return 0;
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 4);
    if (r < 3) return 32'h8000_0000 + (32'(r) << 26) + ($urandom & 32'h03FF_FFFF);
    else return $urandom;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_paddr"}, Paddr, 32'd0);
    chk({tag, "_pwrite"}, 32'(Pwrite), 32'd0);
    chk({tag, "_psel"}, 32'(Pselx), 32'd0);
    chk({tag, "_penable"}, 32'(Penable), 32'd0);
    chk({tag, "_pwdata"}, Pwdata, 32'd0);
  endtask

  // Runs one transfer starting at a negedge where the scheduler is idle and
  // returns at the negedge of the following idle cycle.
  task automatic run_xfer(input string tag, input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                          input logic [AW-1:0] a_v, input logic [AW-1:0] d_v, input int nwait,
                          input logic [31:0] sdata, input logic serr, input bit scramble);
    int          g, nacc;
    bit          tmo;
    logic [31:0] a, d, oh;
    logic [2:0]  sel;
    g   = pick(r, m_ptr);
    a   = slot(a_v, g);
    d   = slot(d_v, g);
    sel = exp_sel(a);
    oh  = 32'd1 << g;
    tmo = (nwait >= TIMEOUT);
    nacc = tmo ? TIMEOUT : nwait + 1;
    req = r; req_write = w; req_addr = a_v; req_wdata = d_v;
    Pready = 1'($urandom); Prdata = $urandom; Pslverr = 1'($urandom);
    chk({tag, "_idle_gnt"}, 32'(gnt), 32'd0);
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(gnt), oh);
    Pready = 1'($urandom); Prdata = $urandom; Pslverr = 1'($urandom);
    if (scramble) begin
      req = NREQ'($urandom); req_addr = {$urandom, $urandom, $urandom}; req_wdata = {$urandom, $urandom, $urandom};
    end
    if (sel == 3'b000) begin
      chk({tag, "_err_done"}, 32'(done), oh);
      chk({tag, "_err_err"}, 32'(rsp_err), 32'd1);
      chk({tag, "_err_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_err_psel"}, 32'(Pselx), 32'd0);
      chk({tag, "_err_penable"}, 32'(Penable), 32'd0);
    end else begin
      chk({tag, "_setup_psel"}, 32'(Pselx), 32'(sel));
      chk({tag, "_setup_penable"}, 32'(Penable), 32'd0);
      chk({tag, "_setup_paddr"}, Paddr, a);
      chk({tag, "_setup_pwrite"}, 32'(Pwrite), 32'(1'(w >> g)));
      chk({tag, "_setup_pwdata"}, Pwdata, d);
      chk({tag, "_setup_done"}, 32'(done), 32'd0);
      for (int k = 0; k < nacc; k++) begin
        @(negedge clk);
        chk({tag, "_acc_penable"}, 32'(Penable), 32'd1);
        chk({tag, "_acc_psel"}, 32'(Pselx), 32'(sel));
        chk({tag, "_acc_paddr"}, Paddr, a);
        chk({tag, "_acc_pwdata"}, Pwdata, d);
        chk({tag, "_acc_done"}, 32'(done), 32'd0);
        chk({tag, "_acc_gnt"}, 32'(gnt), oh);
        Pready  = !tmo && (k == nwait);
        Prdata  = (k == nwait) ? sdata : $urandom;
        Pslverr = (k == nwait) ? serr : 1'($urandom);
      end
      @(negedge clk);
      chk({tag, "_resp_done"}, 32'(done), oh);
      chk({tag, "_resp_rdata"}, rsp_rdata, tmo ? 32'd0 : sdata);
      chk({tag, "_resp_err"}, 32'(rsp_err), tmo ? 32'd1 : 32'(serr));
      chk({tag, "_resp_psel"}, 32'(Pselx), 32'd0);
      chk({tag, "_resp_penable"}, 32'(Penable), 32'd0);
      chk({tag, "_resp_gnt"}, 32'(gnt), oh);
      Pready = 1'($urandom); Prdata = $urandom; Pslverr = 1'($urandom);
    end
    @(negedge clk);
    chk({tag, "_end_done"}, 32'(done), 32'd0);
    chk({tag, "_end_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_end_psel"}, 32'(Pselx), 32'd0);
    m_ptr = (g + 1) % NREQ;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    Pready = 1'b0; Prdata = 32'd0; Pslverr = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Single zero-wait read.
    ad = put('0, 0, 32'h8000_0010);
    wd = {$urandom, $urandom, $urandom};
    run_xfer("t1_read", 3'b001, 3'b000, ad, wd, 0, 32'hCAFE_F00D, 1'b0, 1'b0);

    // Write with three wait states.
    ad = put('0, 1, 32'h8400_0004);
    wd = put('0, 1, 32'h1234_5678);
    run_xfer("t2_write", 3'b010, 3'b010, ad, wd, 3, 32'h0BAD_BEEF, 1'b0, 1'b0);

    // Move the pointer back to 0, then all three requesting continuously.
    ad = {32'h8800_0000, 32'h8400_0000, 32'h8000_0000};
    run_xfer("t3_pre", 3'b100, 3'b000, ad, wd, 0, 32'h1111_2222, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++)
      run_xfer("t3_rr", 3'b111, 3'b101, ad, wd, n % 2, $urandom, 1'b0, 1'b0);

    // Unmapped address.
    ad = put('0, 0, 32'h9000_0000);
    run_xfer("t4_unmapped", 3'b001, 3'b000, ad, wd, 0, 32'h0, 1'b0, 1'b0);

    // Slave error, last wait before timeout, and timeout.
    ad = put('0, 1, 32'h8800_0100);
    run_xfer("slverr", 3'b010, 3'b000, ad, wd, 1, 32'h5555_AAAA, 1'b1, 1'b0);
    run_xfer("wait15", 3'b010, 3'b000, ad, wd, TIMEOUT - 1, 32'h7777_0001, 1'b0, 1'b0);
    run_xfer("t5_timeout", 3'b010, 3'b000, ad, wd, TIMEOUT + 4, 32'h7777_0002, 1'b0, 1'b0);

    // Decode window edges.
    run_xfer("edge_lo", 3'b001, 3'b000, put('0, 0, 32'h83FF_FFFC), wd, 0, 32'hA0, 1'b0, 1'b0);
    run_xfer("edge_hi", 3'b001, 3'b000, put('0, 0, 32'h8BFF_FFFF), wd, 0, 32'hA1, 1'b0, 1'b0);
    run_xfer("edge_above", 3'b001, 3'b000, put('0, 0, 32'h8C00_0000), wd, 0, 32'hA2, 1'b0, 1'b0);
    run_xfer("edge_below", 3'b001, 3'b000, put('0, 0, 32'h7FFF_FFFF), wd, 0, 32'hA3, 1'b0, 1'b0);

    // Randomized traffic, with request fields scrambled after grant.
    for (int n = 0; n < 40; n++) begin
      rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      wr = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        ad = put(ad, i, rand_addr());
        wd = put(wd, i, $urandom);
      end
      waits = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : $urandom_range(0, 4);
      run_xfer("rand", rq, wr, ad, wd, waits, $urandom, 1'($urandom), 1'($urandom));
    end

    // Reset during ACCESS with the pointer away from 0.
    ad = {32'h8800_0000, 32'h8400_0020, 32'h8000_0040};
    run_xfer("t6_pre", 3'b001, 3'b000, ad, wd, 0, 32'h1, 1'b0, 1'b0);
    req = 3'b010; req_addr = ad; Pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_access", 32'(Penable), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("t6_rst");
    rst = 1'b0; req = '0; Pready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_done", 32'(done), 32'd0);
      chk("t6_no_psel", 32'(Pselx), 32'd0);
    end
    m_ptr = 0;
    run_xfer("t6_fresh", 3'b111, 3'b000, ad, wd, 0, 32'h2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
